// File: rtl/unidade_controle.sv
// Control FSM for the 9-bit-instruction processor: steps each instruction through T0..T3
// and decodes IR into register-file, bus, ALU and Done controls.
module unidade_controle #(
  parameter bit ENABLE_MVNZ = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [8:0] IR,
  input  logic       Gnz,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic       DINout,
  output logic       AddSub,
  output logic       Done,
  output logic [1:0] Tstep
);

  typedef enum logic [1:0] {StT0, StT1, StT2, StT3} tstep_e;

  tstep_e     state_q, state_d;
  logic [2:0] opcode;
  logic [7:0] x_oh, y_oh;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StT0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    opcode  = IR[8:6];
    x_oh    = 8'b1 << IR[5:3];
    y_oh    = 8'b1 << IR[2:0];
    state_d = state_q;
    IRin    = 1'b0;
    Rin     = 8'h00;
    Rout    = 8'h00;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    DINout  = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    Tstep   = state_q;

    unique case (state_q)
      StT0: begin
        IRin    = Run;
        state_d = Run ? StT1 : StT0;
      end
      StT1: begin
        case (opcode)
          3'b000: begin
            Rout = y_oh;
            Rin  = x_oh;
            Done = 1'b1;
          end
          3'b001: begin
            DINout = 1'b1;
            Rin    = x_oh;
            Done   = 1'b1;
          end
          3'b010, 3'b011: begin
            Rout    = x_oh;
            Ain     = 1'b1;
            state_d = StT2;
          end
          3'b100: begin
            Done = 1'b1;
            if (ENABLE_MVNZ && Gnz) begin
              Rout = y_oh;
              Rin  = x_oh;
            end
          end
          default: Done = 1'b1;
        endcase
      end
      StT2: begin
        // Only add/sub reach T2; anything else just retires so the FSM cannot stall.
        if (opcode[2:1] == 2'b01) begin
          Rout    = y_oh;
          Gin     = 1'b1;
          AddSub  = opcode[0];
          state_d = StT3;
        end else begin
          Done = 1'b1;
        end
      end
      StT3: begin
        Gout = 1'b1;
        Rin  = x_oh;
        Done = 1'b1;
      end
    endcase

    if (Done) begin
      state_d = StT0;
    end

    // Reset squashes every output in the same cycle so no partial write can escape.
    if (Reset) begin
      IRin   = 1'b0;
      Rin    = 8'h00;
      Rout   = 8'h00;
      Ain    = 1'b0;
      Gin    = 1'b0;
      Gout   = 1'b0;
      DINout = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
      Tstep  = 2'd0;
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: directed scenarios plus a random instruction stream checked
// against a step-list model built from the instruction semantics.
module tb_unidade_controle;

  localparam bit MvnzEn = 1'b1;

  logic       Clock = 1'b0;
  logic       Reset, Run, Gnz;
  logic [8:0] IR;
  logic       IRin, Ain, Gin, Gout, DINout, AddSub, Done;
  logic [7:0] Rin, Rout;
  logic [1:0] Tstep;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic       addsub;
    logic       done;
    logic [1:0] tstep;
  } outs_t;

  unidade_controle #(.ENABLE_MVNZ(MvnzEn)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Run   (Run),
    .IR    (IR),
    .Gnz   (Gnz),
    .IRin  (IRin),
    .Rin   (Rin),
    .Rout  (Rout),
    .Ain   (Ain),
    .Gin   (Gin),
    .Gout  (Gout),
    .DINout(DINout),
    .AddSub(AddSub),
    .Done  (Done),
    .Tstep (Tstep)
  );

  always #5 Clock = ~Clock;

  function automatic outs_t sample();
    outs_t s;
    s.irin = IRin;  s.rin = Rin;  s.rout = Rout;  s.ain = Ain;  s.gin = Gin;
    s.gout = Gout;  s.dinout = DINout;  s.addsub = AddSub;  s.done = Done;  s.tstep = Tstep;
    return s;
  endfunction

  function automatic outs_t ex(logic [1:0] t, logic irin, logic [7:0] rin, logic [7:0] rout,
                               logic ain, logic gin, logic gout, logic din, logic as,
                               logic done);
    outs_t e;
    e.irin = irin;  e.rin = rin;  e.rout = rout;  e.ain = ain;  e.gin = gin;
    e.gout = gout;  e.dinout = din;  e.addsub = as;  e.done = done;  e.tstep = t;
    return e;
  endfunction

  // Inputs change just after the negedge; outputs are sampled 2 time units later.
  task automatic next_cycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic test_reset();
    outs_t o;
    Reset = 1'b1; Run = 1'b1; Gnz = 1'b1; IR = 9'b000_000_000;
    for (int i = 0; i < 2; i++) begin
      #2 o = sample();
      n_checks++;
      if (o !== '0) $display("FAIL reset_cycle%0d: got %h want %h", i, o, outs_t'('0));
      else n_pass++;
      next_cycle();
    end
    Reset = 1'b0;
    #2 o = sample();
    n_checks++;
    if (o !== ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL reset_release_irin: got %h want %h", o, ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    else n_pass++;
    next_cycle();
    Run = 1'b0;
    #2 o = sample();
    n_checks++;
    if (o !== ex(1, 0, 8'h01, 8'h01, 0, 0, 0, 0, 0, 1))
      $display("FAIL mv_r0_r0: got %h want %h", o, ex(1, 0, 8'h01, 8'h01, 0, 0, 0, 0, 0, 1));
    else n_pass++;
    next_cycle();
    #2 o = sample();
    n_checks++;
    if (o !== '0) $display("FAIL idle_after_reset: got %h want %h", o, outs_t'('0));
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_mv();
    outs_t o;
    IR = 9'b000_011_101; Run = 1'b1; Gnz = 1'b0;
    #2 o = sample();
    n_checks++;
    if (o !== ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL mv_t0: got %h want %h", o, ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    else n_pass++;
    next_cycle();
    Run = 1'b0;
    #2 o = sample();
    n_checks++;
    if (o !== ex(1, 0, 8'h08, 8'h20, 0, 0, 0, 0, 0, 1))
      $display("FAIL mv_t1: got %h want %h", o, ex(1, 0, 8'h08, 8'h20, 0, 0, 0, 0, 0, 1));
    else n_pass++;
    next_cycle();
    #2 o = sample();
    n_checks++;
    if (o !== '0) $display("FAIL mv_back_to_t0: got %h want %h", o, outs_t'('0));
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_sub();
    outs_t o;
    outs_t exp_seq [4];
    exp_seq[0] = ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_seq[1] = ex(1, 0, 0, 8'h02, 1, 0, 0, 0, 0, 0);
    exp_seq[2] = ex(2, 0, 0, 8'h04, 0, 1, 0, 0, 1, 0);
    exp_seq[3] = ex(3, 0, 8'h02, 0, 0, 0, 1, 0, 0, 1);
    IR = 9'b011_001_010; Run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 o = sample();
      n_checks++;
      if (o !== exp_seq[i]) $display("FAIL sub_t%0d: got %h want %h", i, o, exp_seq[i]);
      else n_pass++;
      next_cycle();
      Run = 1'b0;
    end
  endtask

  task automatic test_mvnz();
    outs_t o;
    outs_t want;
    for (int g = 0; g < 2; g++) begin
      IR = 9'b100_000_111; Run = 1'b1; Gnz = g[0];
      next_cycle();
      Run = 1'b0;
      want = (g == 1 && MvnzEn) ? ex(1, 0, 8'h01, 8'h80, 0, 0, 0, 0, 0, 1)
                                : ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #2 o = sample();
      n_checks++;
      if (o !== want) $display("FAIL mvnz_gnz%0d: got %h want %h", g, o, want);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_and_run_toggle();
    outs_t o;
    outs_t want;
    IR = 9'b010_001_010; Run = 1'b1; Gnz = 1'b0;
    next_cycle();
    Run = 1'b0;
    next_cycle();
    Reset = 1'b1;
    #2 o = sample();
    n_checks++;
    if (o !== '0) $display("FAIL reset_in_t2: got %h want %h", o, outs_t'('0));
    else n_pass++;
    next_cycle();
    Reset = 1'b0;
    #2 o = sample();
    n_checks++;
    if (o !== '0) $display("FAIL after_mid_reset: got %h want %h", o, outs_t'('0));
    else n_pass++;
    // Second add: Run wiggles during T1..T3 and must be ignored.
    IR = 9'b010_010_010; Run = 1'b1;
    next_cycle();
    Run = 1'b1;
    next_cycle();
    Run = 1'b0;
    #2 o = sample();
    want = ex(2, 0, 0, 8'h04, 0, 1, 0, 0, 0, 0);
    n_checks++;
    if (o !== want) $display("FAIL add_t2_run_toggle: got %h want %h", o, want);
    else n_pass++;
    next_cycle();
    Run = 1'b1;
    #2 o = sample();
    want = ex(3, 0, 8'h04, 0, 0, 0, 1, 0, 0, 1);
    n_checks++;
    if (o !== want) $display("FAIL add_t3_run_toggle: got %h want %h", o, want);
    else n_pass++;
    next_cycle();
    Run = 1'b0;
    #2 o = sample();
    n_checks++;
    if (o !== '0) $display("FAIL add_done_to_t0: got %h want %h", o, outs_t'('0));
    else n_pass++;
    next_cycle();
  endtask

  // Reference model: list of per-step output records for one instruction issued from T0.
  task automatic build_expected(input logic [8:0] ir, input logic gnz, output outs_t q[$]);
    int op, x, y;
    logic [7:0] xo, yo;
    op = int'(ir[8:6]); x = int'(ir[5:3]); y = int'(ir[2:0]);
    xo = 8'(1 << x); yo = 8'(1 << y);
    q = {};
    q.push_back(ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    if (op == 0)                  q.push_back(ex(1, 0, xo, yo, 0, 0, 0, 0, 0, 1));
    else if (op == 1)             q.push_back(ex(1, 0, xo, 0, 0, 0, 0, 1, 0, 1));
    else if (op == 2 || op == 3) begin
      q.push_back(ex(1, 0, 0, xo, 1, 0, 0, 0, 0, 0));
      q.push_back(ex(2, 0, 0, yo, 0, 1, 0, 0, (op == 3), 0));
      q.push_back(ex(3, 0, xo, 0, 0, 0, 1, 0, 0, 1));
    end else if (op == 4 && MvnzEn && gnz) q.push_back(ex(1, 0, xo, yo, 0, 0, 0, 0, 0, 1));
    else                          q.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic test_random_stream();
    outs_t q[$];
    outs_t o;
    int unsigned dones = 0;
    int unsigned bus;
    for (int n = 0; n < 500; n++) begin
      Run = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        #2 o = sample();
        n_checks++;
        if (o !== '0) $display("FAIL rand_idle: got %h want %h", o, outs_t'('0));
        else n_pass++;
        next_cycle();
      end
      IR  = 9'($urandom);
      Gnz = 1'($urandom);
      build_expected(IR, Gnz, q);
      Run = 1'b1;
      for (int i = 0; i < q.size(); i++) begin
        #2 o = sample();
        n_checks++;
        if (o !== q[i]) $display("FAIL rand_step ir=%b t%0d: got %h want %h", IR, i, o, q[i]);
        else n_pass++;
        bus = $countones(Rout) + 32'(Gout) + 32'(DINout);
        n_checks++;
        if (bus > 1 || $countones(Rin) > 1)
          $display("FAIL rand_exclusive: got bus_drivers=%0d rin=%h want <=1 each", bus, Rin);
        else n_pass++;
        if (Done === 1'b1) dones++;
        next_cycle();
        Run = 1'($urandom);
      end
    end
    Run = 1'b0;
    n_checks++;
    if (dones != 500) $display("FAIL rand_done_count: got %0d want 500", dones);
    else n_pass++;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Gnz = 1'b0; IR = '0;
    @(negedge Clock);
    test_reset();
    test_mv();
    test_sub();
    test_mvnz();
    test_reset_mid_and_run_toggle();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
